// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch unit: IDLE -> FETCH -> EXEC loop with PC select,
// sticky misalignment halt and a saturating fetch-stall counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      imem,
  input  logic [1:0]        PCSrc,
  input  logic [31:0]       PCTarget,
  input  logic [31:0]       ALUResult,
  input  logic              exec_done,
  output logic              instr_valid,
  output logic [31:0]       Instr,
  output logic [31:0]       PC,
  output logic [31:0]       PCPlus4,
  output logic [6:0]        Opcode,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic              misaligned,
  output logic [15:0]       stall_cycles
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_misaligned;
  logic [15:0] r_stall;
  logic [31:0] w_next_pc;
  logic        w_load_instr;
  logic        w_stall;
  logic        w_commit;
  logic        w_halt;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (PCSrc)
      2'b01:   w_next_pc = PCTarget;
      2'b10:   w_next_pc = ALUResult;
      default: w_next_pc = w_pc_plus4;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load_instr  = 1'b0;
    w_stall       = 1'b0;
    w_commit      = 1'b0;
    w_halt        = 1'b0;
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          w_load_instr = 1'b1;
          w_state_nxt  = S_EXEC;
        end else begin
          w_stall = 1'b1;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          if (w_next_pc[1:0] == 2'b00) begin
            w_commit    = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_halt      = 1'b1;
            w_state_nxt = S_HALT;
          end
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_instr      <= NOP;
      r_misaligned <= 1'b0;
      r_stall      <= '0;
    end else begin
      if (w_load_instr) r_instr <= imem.imem_rdata;
      if (w_commit) r_pc <= w_next_pc;
      if (w_halt) r_misaligned <= 1'b1;
      // Counter sticks at all-ones rather than wrapping.
      if (w_stall && (r_stall != '1)) r_stall <= r_stall + 16'd1;
    end
  end

  assign imem.imem_addr = r_pc;
  assign Instr          = r_instr;
  assign PC             = r_pc;
  assign PCPlus4        = w_pc_plus4;
  assign Opcode         = r_instr[6:0];
  assign funct3         = r_instr[14:12];
  assign funct7         = r_instr[31:25];
  assign misaligned     = r_misaligned;
  assign stall_cycles   = r_stall;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// fetch/execute sequence checked against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [1:0]  PCSrc;
  logic [31:0] PCTarget;
  logic [31:0] ALUResult;
  logic        exec_done;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [6:0]  Opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        misaligned;
  logic [15:0] stall_cycles;

  int n_pass;
  int n_total;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int          m_stall;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (bus),
    .PCSrc        (PCSrc),
    .PCTarget     (PCTarget),
    .ALUResult    (ALUResult),
    .exec_done    (exec_done),
    .instr_valid  (instr_valid),
    .Instr        (Instr),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .Opcode       (Opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .misaligned   (misaligned),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first FETCH cycle, sampled 1 time unit after the edge.
  task automatic do_reset;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    exec_done = 1'b0;
    PCSrc = 2'b00;
    PCTarget = '0;
    ALUResult = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    m_pc = RST_PC;
    m_instr = NOP;
    m_stall = 0;
  endtask

  task automatic fetch_now(input logic [31:0] word);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_ack = 1'b0;
    m_instr = word;
  endtask

  task automatic commit(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
    exec_done = 1'b1;
    PCSrc = src;
    PCTarget = tgt;
    ALUResult = alu;
    tick();
    exec_done = 1'b0;
  endtask

  // From EXEC, jump to pc and fetch a NOP there, ending in EXEC at pc.
  task automatic goto_pc(input logic [31:0] pc);
    commit(2'b01, pc, 32'h0);
    fetch_now(NOP);
    m_pc = pc;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    #2;
    rst = 1'b0;
    #1;
    n_total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b exp 0", bus.imem_req); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", instr_valid); else n_pass++;
    n_total++; if (PC !== RST_PC) $display("FAIL reset_pc: got %h exp %h", PC, RST_PC); else n_pass++;
    n_total++; if (Instr !== NOP) $display("FAIL reset_instr: got %h exp %h", Instr, NOP); else n_pass++;
    n_total++; if (misaligned !== 1'b0) $display("FAIL reset_mis: got %b exp 0", misaligned); else n_pass++;
    n_total++; if (stall_cycles !== 16'h0) $display("FAIL reset_stall: got %h exp 0", stall_cycles); else n_pass++;
  endtask

  task automatic test_first_fetch;
    do_reset();
    n_total++; if (bus.imem_req !== 1'b1) $display("FAIL first_req: got %b exp 1", bus.imem_req); else n_pass++;
    n_total++; if (bus.imem_addr !== RST_PC) $display("FAIL first_addr: got %h exp %h", bus.imem_addr, RST_PC); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL first_valid_fetch: got %b exp 0", instr_valid); else n_pass++;
    fetch_now(32'h0050_0093);
    n_total++; if (Instr !== 32'h0050_0093) $display("FAIL first_instr: got %h exp 00500093", Instr); else n_pass++;
    n_total++; if (Opcode !== 7'h13) $display("FAIL first_opcode: got %h exp 13", Opcode); else n_pass++;
    n_total++; if (funct3 !== 3'h0) $display("FAIL first_funct3: got %h exp 0", funct3); else n_pass++;
    n_total++; if (instr_valid !== 1'b1) $display("FAIL first_valid: got %b exp 1", instr_valid); else n_pass++;
    n_total++; if (PC !== 32'h0) $display("FAIL first_pc: got %h exp 0", PC); else n_pass++;
    n_total++; if (bus.imem_req !== 1'b0) $display("FAIL first_req_exec: got %b exp 0", bus.imem_req); else n_pass++;
  endtask

  task automatic test_next_pc;
    logic [1:0]  src [4]  = '{2'b00, 2'b11, 2'b01, 2'b10};
    logic [31:0] expv [4] = '{32'h104, 32'h104, 32'h80, 32'h200};
    do_reset();
    fetch_now(NOP);
    goto_pc(32'h100);
    for (int i = 0; i < 4; i++) begin
      commit(src[i], 32'h80, 32'h200);
      n_total++; if (PC !== expv[i]) $display("FAIL nextpc_%0d: got %h exp %h", i, PC, expv[i]); else n_pass++;
      n_total++; if (bus.imem_req !== 1'b1) $display("FAIL nextpc_req_%0d: got %b exp 1", i, bus.imem_req); else n_pass++;
      n_total++; if (bus.imem_addr !== expv[i]) $display("FAIL nextpc_addr_%0d: got %h exp %h", i, bus.imem_addr, expv[i]); else n_pass++;
      fetch_now(NOP);
      goto_pc(32'h100);
    end
    goto_pc(32'hFFFF_FFFC);
    n_total++; if (PCPlus4 !== 32'h0) $display("FAIL wrap_plus4: got %h exp 0", PCPlus4); else n_pass++;
    commit(2'b00, 32'h0, 32'h0);
    n_total++; if (PC !== 32'h0) $display("FAIL wrap_pc: got %h exp 0", PC); else n_pass++;
  endtask

  task automatic test_misaligned;
    do_reset();
    fetch_now(32'h1234_5067);
    goto_pc(32'h100);
    commit(2'b10, 32'h80, 32'h202);
    n_total++; if (misaligned !== 1'b1) $display("FAIL mis_flag: got %b exp 1", misaligned); else n_pass++;
    n_total++; if (PC !== 32'h100) $display("FAIL mis_pc: got %h exp 100", PC); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      exec_done = 1'b1;
      PCSrc = 2'b00;
      tick();
      n_total++; if (bus.imem_req !== 1'b0) $display("FAIL halt_req_%0d: got %b exp 0", i, bus.imem_req); else n_pass++;
      n_total++; if (instr_valid !== 1'b0) $display("FAIL halt_valid_%0d: got %b exp 0", i, instr_valid); else n_pass++;
      n_total++; if (PC !== 32'h100) $display("FAIL halt_pc_%0d: got %h exp 100", i, PC); else n_pass++;
      n_total++; if (Instr !== NOP) $display("FAIL halt_instr_%0d: got %h exp %h", i, Instr, NOP); else n_pass++;
    end
    bus.imem_ack = 1'b0;
    exec_done = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_total++; if (misaligned !== 1'b0) $display("FAIL mis_clear: got %b exp 0", misaligned); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_stall;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    n_total++; if (stall_cycles !== 16'd5) $display("FAIL stall_5: got %0d exp 5", stall_cycles); else n_pass++;
    for (int i = 5; i < 65534; i++) tick();
    n_total++; if (stall_cycles !== 16'hFFFE) $display("FAIL stall_fffe: got %h exp fffe", stall_cycles); else n_pass++;
    tick();
    n_total++; if (stall_cycles !== 16'hFFFF) $display("FAIL stall_ffff: got %h exp ffff", stall_cycles); else n_pass++;
    for (int i = 65535; i < 70000; i++) tick();
    n_total++; if (stall_cycles !== 16'hFFFF) $display("FAIL stall_sat: got %h exp ffff", stall_cycles); else n_pass++;
    n_total++; if (bus.imem_req !== 1'b1) $display("FAIL stall_req: got %b exp 1", bus.imem_req); else n_pass++;
  endtask

  task automatic test_reset_abort;
    do_reset();
    fetch_now(NOP);
    goto_pc(32'h100);
    commit(2'b00, 32'h0, 32'h0);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hCAFE_F00D;
    #2;
    rst = 1'b0;
    #1;
    n_total++; if (bus.imem_req !== 1'b0) $display("FAIL abort_req_async: got %b exp 0", bus.imem_req); else n_pass++;
    tick();
    n_total++; if (Instr !== NOP) $display("FAIL abort_instr: got %h exp %h", Instr, NOP); else n_pass++;
    n_total++; if (PC !== RST_PC) $display("FAIL abort_pc: got %h exp %h", PC, RST_PC); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL abort_valid: got %b exp 0", instr_valid); else n_pass++;
    bus.imem_ack = 1'b0;
    rst = 1'b1;
    tick();
    n_total++; if (bus.imem_req !== 1'b1) $display("FAIL abort_refetch_req: got %b exp 1", bus.imem_req); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL abort_no_exec: got %b exp 0", instr_valid); else n_pass++;
    n_total++; if (bus.imem_addr !== RST_PC) $display("FAIL abort_addr: got %h exp %h", bus.imem_addr, RST_PC); else n_pass++;
  endtask

  task automatic test_random;
    int          k;
    logic [31:0] word;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] alu;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 3);
      for (int s = 0; s < k; s++) begin
        bus.imem_ack = 1'b0;
        exec_done = $urandom_range(0, 1) == 1;
        PCSrc = 2'($urandom);
        tick();
        if (m_stall < 65535) m_stall++;
        n_total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) $display("FAIL rnd_stall_req: req %b addr %h exp addr %h", bus.imem_req, bus.imem_addr, m_pc); else n_pass++;
      end
      exec_done = 1'b0;
      word = $urandom;
      fetch_now(word);
      n_total++; if (Instr !== m_instr) $display("FAIL rnd_instr: got %h exp %h", Instr, m_instr); else n_pass++;
      n_total++; if ({funct7, funct3, Opcode} !== {m_instr[31:25], m_instr[14:12], m_instr[6:0]}) $display("FAIL rnd_fields: got %h/%h/%h exp %h", funct7, funct3, Opcode, m_instr); else n_pass++;
      n_total++; if (stall_cycles !== 16'(m_stall)) $display("FAIL rnd_stall_cnt: got %0d exp %0d", stall_cycles, m_stall); else n_pass++;
      k = $urandom_range(0, 2);
      for (int e = 0; e < k; e++) begin
        bus.imem_ack = 1'b1;
        bus.imem_rdata = $urandom;
        PCSrc = 2'($urandom);
        PCTarget = $urandom;
        ALUResult = $urandom;
        tick();
        n_total++; if (instr_valid !== 1'b1 || Instr !== m_instr || PC !== m_pc) $display("FAIL rnd_exec_hold: valid %b instr %h pc %h exp %h %h", instr_valid, Instr, PC, m_instr, m_pc); else n_pass++;
      end
      bus.imem_ack = 1'b0;
      src = 2'($urandom);
      tgt = $urandom & 32'hFFFF_FFFC;
      alu = $urandom & 32'hFFFF_FFFC;
      commit(src, tgt, alu);
      case (src)
        2'b01:   m_pc = tgt;
        2'b10:   m_pc = alu;
        default: m_pc = m_pc + 32'd4;
      endcase
      n_total++; if (PC !== m_pc || bus.imem_req !== 1'b1) $display("FAIL rnd_commit: pc %h req %b exp pc %h", PC, bus.imem_req, m_pc); else n_pass++;
      n_total++; if (PCPlus4 !== m_pc + 32'd4) $display("FAIL rnd_plus4: got %h exp %h", PCPlus4, m_pc + 32'd4); else n_pass++;
      n_total++; if (misaligned !== 1'b0) $display("FAIL rnd_mis: got %b exp 0", misaligned); else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    exec_done = 1'b0;
    PCSrc = 2'b00;
    PCTarget = '0;
    ALUResult = '0;
    m_pc = RST_PC;
    m_instr = NOP;
    m_stall = 0;
    test_reset();
    test_first_fetch();
    test_next_pc();
    test_misaligned();
    test_reset_abort();
    test_random();
    test_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
